// File: rtl/triangle_rasterizer_if.sv
// -----------------------------------------------------------------------------
// triangle_rasterizer_if
//
// Purpose : Groups the job-control and point-stream signals of the triangle
//           rasterizer into one bundle. Signal prefixes are from the
//           rasterizer's point of view (i_ = into the rasterizer, o_ = out).
//
// Parameters:
//   W  - coordinate width in bits (unsigned)
//   CW - width of the handed-off point counter
//
// Signals:
//   i_start                  begin a job (sampled only while o_busy = 0)
//   i_xa..i_yc               triangle vertices, sampled with i_start
//   i_out_ready              consumer accepts the presented point
//   o_busy                   job in progress (through the done cycle)
//   o_out_valid              o_out_x/o_out_y hold an interior point
//   o_out_x, o_out_y         interior point coordinates
//   o_done                   one-cycle end-of-job pulse
//   o_count                  points handed off in the current/last job
//
// Modports:
//   slave  - the rasterizer itself
//   master - the job issuer / point consumer
// -----------------------------------------------------------------------------
interface triangle_rasterizer_if #(
  parameter int W  = 10,
  parameter int CW = 2*W+1
);
  logic          i_start;
  logic [W-1:0]  i_xa;
  logic [W-1:0]  i_ya;
  logic [W-1:0]  i_xb;
  logic [W-1:0]  i_yb;
  logic [W-1:0]  i_xc;
  logic [W-1:0]  i_yc;
  logic          i_out_ready;
  logic          o_busy;
  logic          o_out_valid;
  logic [W-1:0]  o_out_x;
  logic [W-1:0]  o_out_y;
  logic          o_done;
  logic [CW-1:0] o_count;

  modport slave (
    input  i_start, i_xa, i_ya, i_xb, i_yb, i_xc, i_yc, i_out_ready,
    output o_busy, o_out_valid, o_out_x, o_out_y, o_done, o_count
  );

  modport master (
    output i_start, i_xa, i_ya, i_xb, i_yb, i_xc, i_yc, i_out_ready,
    input  o_busy, o_out_valid, o_out_x, o_out_y, o_done, o_count
  );
endinterface

// File: rtl/triangle_rasterizer.sv
// -----------------------------------------------------------------------------
// triangle_rasterizer
//
// Purpose : Takes one triangle (three unsigned integer vertices) and streams
//           out, one per valid/ready handshake, every integer grid point that
//           lies strictly inside it. The triangle's bounding box is scanned in
//           row-major order (y outer, x inner, both ascending) and each
//           candidate is classified with three edge functions; a point is
//           inside when all three have the same strict sign, so either
//           winding works and edge/vertex points are never emitted.
//
// Ports:
//   i_clk  - clock, rising edge
//   i_rst  - asynchronous, active-high reset
//   bus    - triangle_rasterizer_if.slave (job control + point stream)
//
// Parameters:
//   W  - coordinate width (default 10)
//   CW - counter width (default 2*W+1)
// -----------------------------------------------------------------------------
module triangle_rasterizer #(
  parameter int W  = 10,
  parameter int CW = 2*W+1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  triangle_rasterizer_if.slave   bus
);

  // Edge-function value width: difference W+1, product 2W+2, sum 2W+3.
  localparam int EW = 2*W+3;
  localparam int PW = 2*W+2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SCAN  = 3'd2,
    S_EMIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic logic [W-1:0] min3(input logic [W-1:0] p,
                                        input logic [W-1:0] q,
                                        input logic [W-1:0] r);
    logic [W-1:0] m;
    m = (p < q) ? p : q;
    m = (m < r) ? m : r;
    return m;
  endfunction

  function automatic logic [W-1:0] max3(input logic [W-1:0] p,
                                        input logic [W-1:0] q,
                                        input logic [W-1:0] r);
    logic [W-1:0] m;
    m = (p > q) ? p : q;
    m = (m > r) ? m : r;
    return m;
  endfunction

  // Edge function (px-x0)(y1-y0) - (py-y0)(x1-x0), computed at full width
  // so no vertex placement in the unsigned W-bit range can overflow.
  function automatic logic signed [EW-1:0] edge_fn(input logic [W-1:0] px,
                                                   input logic [W-1:0] py,
                                                   input logic [W-1:0] x0,
                                                   input logic [W-1:0] y0,
                                                   input logic [W-1:0] x1,
                                                   input logic [W-1:0] y1);
    logic signed [W:0]    dpx;
    logic signed [W:0]    dpy;
    logic signed [W:0]    dex;
    logic signed [W:0]    dey;
    logic signed [PW-1:0] p0;
    logic signed [PW-1:0] p1;
    dpx = $signed({1'b0, px}) - $signed({1'b0, x0});
    dpy = $signed({1'b0, py}) - $signed({1'b0, y0});
    dex = $signed({1'b0, x1}) - $signed({1'b0, x0});
    dey = $signed({1'b0, y1}) - $signed({1'b0, y0});
    p0  = $signed({{(W+1){dpx[W]}}, dpx}) * $signed({{(W+1){dey[W]}}, dey});
    p1  = $signed({{(W+1){dpy[W]}}, dpy}) * $signed({{(W+1){dex[W]}}, dex});
    return $signed({p0[PW-1], p0}) - $signed({p1[PW-1], p1});
  endfunction

  // Strictly positive: sign bit clear and not zero.
  function automatic logic is_pos(input logic signed [EW-1:0] v);
    return ~v[EW-1] & (|v);
  endfunction

  // Strictly negative: sign bit set.
  function automatic logic is_neg(input logic signed [EW-1:0] v);
    return v[EW-1];
  endfunction

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_t         r_state;
  logic [W-1:0]   r_xa, r_ya, r_xb, r_yb, r_xc, r_yc;
  logic [W-1:0]   r_xmin, r_xmax, r_ymin, r_ymax;
  logic [W-1:0]   r_cx, r_cy;
  logic           r_busy;
  logic           r_out_valid;
  logic [W-1:0]   r_out_x, r_out_y;
  logic           r_done;
  logic [CW-1:0]  r_count;

  logic signed [EW-1:0] w_ea, w_eb, w_ec;
  logic                 w_inside;
  logic                 w_last;
  logic [W-1:0]         w_next_cx;
  logic [W-1:0]         w_next_cy;

  // Classify the current scan candidate against the latched triangle.
  always_comb begin
    w_ea     = edge_fn(r_cx, r_cy, r_xa, r_ya, r_xb, r_yb);
    w_eb     = edge_fn(r_cx, r_cy, r_xb, r_yb, r_xc, r_yc);
    w_ec     = edge_fn(r_cx, r_cy, r_xc, r_yc, r_xa, r_ya);
    w_inside = (is_pos(w_ea) & is_pos(w_eb) & is_pos(w_ec)) |
               (is_neg(w_ea) & is_neg(w_eb) & is_neg(w_ec));
  end

  // Next scan position and last-candidate detect. Testing cx==xmax /
  // cy==ymax instead of comparing an incremented value keeps the scan
  // correct when the box touches coordinate 2^W-1.
  always_comb begin
    w_last    = (r_cx == r_xmax) && (r_cy == r_ymax);
    w_next_cx = r_cx;
    w_next_cy = r_cy;
    if (r_cx == r_xmax) begin
      w_next_cx = r_xmin;
      w_next_cy = r_cy + {{(W-1){1'b0}}, 1'b1};
    end else begin
      w_next_cx = r_cx + {{(W-1){1'b0}}, 1'b1};
      w_next_cy = r_cy;
    end
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_xa        <= {W{1'b0}};
      r_ya        <= {W{1'b0}};
      r_xb        <= {W{1'b0}};
      r_yb        <= {W{1'b0}};
      r_xc        <= {W{1'b0}};
      r_yc        <= {W{1'b0}};
      r_xmin      <= {W{1'b0}};
      r_xmax      <= {W{1'b0}};
      r_ymin      <= {W{1'b0}};
      r_ymax      <= {W{1'b0}};
      r_cx        <= {W{1'b0}};
      r_cy        <= {W{1'b0}};
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_x     <= {W{1'b0}};
      r_out_y     <= {W{1'b0}};
      r_done      <= 1'b0;
      r_count     <= {CW{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.i_start) begin
            r_xa    <= bus.i_xa;
            r_ya    <= bus.i_ya;
            r_xb    <= bus.i_xb;
            r_yb    <= bus.i_yb;
            r_xc    <= bus.i_xc;
            r_yc    <= bus.i_yc;
            r_count <= {CW{1'b0}};
            r_busy  <= 1'b1;
            r_state <= S_SETUP;
          end else begin
            r_state <= S_IDLE;
          end
        end

        S_SETUP: begin
          r_xmin  <= min3(r_xa, r_xb, r_xc);
          r_xmax  <= max3(r_xa, r_xb, r_xc);
          r_ymin  <= min3(r_ya, r_yb, r_yc);
          r_ymax  <= max3(r_ya, r_yb, r_yc);
          r_cx    <= min3(r_xa, r_xb, r_xc);
          r_cy    <= min3(r_ya, r_yb, r_yc);
          r_state <= S_SCAN;
        end

        S_SCAN: begin
          if (w_inside) begin
            r_out_x     <= r_cx;
            r_out_y     <= r_cy;
            r_out_valid <= 1'b1;
            r_state     <= S_EMIT;
          end else if (w_last) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cx    <= w_next_cx;
            r_cy    <= w_next_cy;
            r_state <= S_SCAN;
          end
        end

        // Point is held until the consumer takes it; the scan position has
        // not moved yet, so the last-candidate test still applies here.
        S_EMIT: begin
          if (r_out_valid && bus.i_out_ready) begin
            r_out_valid <= 1'b0;
            r_count     <= r_count + {{(CW-1){1'b0}}, 1'b1};
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_cx    <= w_next_cx;
              r_cy    <= w_next_cy;
              r_state <= S_SCAN;
            end
          end else begin
            r_state <= S_EMIT;
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_out_valid <= 1'b0;
          r_done      <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_busy      = r_busy;
  assign bus.o_out_valid = r_out_valid;
  assign bus.o_out_x     = r_out_x;
  assign bus.o_out_y     = r_out_y;
  assign bus.o_done      = r_done;
  assign bus.o_count     = r_count;

endmodule

// File: tb/tb_triangle_rasterizer.sv
// -----------------------------------------------------------------------------
// tb_triangle_rasterizer
//
// Directed bench for triangle_rasterizer: hand-computed interior points,
// done-cycle positions (edge 0 = start-sampling edge) and counts.
// -----------------------------------------------------------------------------
module tb_triangle_rasterizer;

  localparam int W  = 10;
  localparam int CW = 2*W+1;

  logic clk;
  logic rst;

  triangle_rasterizer_if #(.W(W), .CW(CW)) bus ();

  triangle_rasterizer #(.W(W), .CW(CW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Expected point list of the job being run.
  int exp_x [0:3];
  int exp_y [0:3];
  int exp_k;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic set_vertices(input int xa, input int ya, input int xb,
                              input int yb, input int xc, input int yc);
    bus.i_xa = xa[W-1:0];
    bus.i_ya = ya[W-1:0];
    bus.i_xb = xb[W-1:0];
    bus.i_yb = yb[W-1:0];
    bus.i_xc = xc[W-1:0];
    bus.i_yc = yc[W-1:0];
  endtask

  // Runs one job with out_ready high except for 'stall' cycles on the first
  // point; checks point order/stability, done edge, count and busy.
  task automatic run_job(input string name, input int xa, input int ya,
                         input int xb, input int yb, input int xc, input int yc,
                         input int stall, input int exp_done);
    int edge_n;
    int idx;
    int stall_left;
    bit seen_done;
    set_vertices(xa, ya, xb, yb, xc, yc);
    bus.i_out_ready = 1'b1;
    bus.i_start     = 1'b1;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    edge_n      = 0;
    chk({name, "_busy_start"}, {31'd0, bus.o_busy}, 32'd1);
    idx        = 0;
    stall_left = stall;
    seen_done  = 1'b0;
    for (int c = 0; c < 300 && !seen_done; c++) begin
      @(posedge clk);
      #1;
      edge_n++;
      if (bus.o_out_valid) begin
        if (idx < exp_k) begin
          chk({name, "_pt_x"}, {22'd0, bus.o_out_x}, exp_x[idx]);
          chk({name, "_pt_y"}, {22'd0, bus.o_out_y}, exp_y[idx]);
        end else begin
          chk({name, "_extra_point"}, 32'd1, 32'd0);
        end
        if (stall_left > 0) begin
          bus.i_out_ready = 1'b0;
          stall_left--;
        end else begin
          bus.i_out_ready = 1'b1;
          idx++;
        end
      end
      if (bus.o_done) begin
        seen_done = 1'b1;
        chk({name, "_done_edge"}, edge_n, exp_done);
        chk({name, "_count"}, {11'd0, bus.o_count}, exp_k);
        chk({name, "_busy_done"}, {31'd0, bus.o_busy}, 32'd1);
      end
    end
    if (!seen_done) chk({name, "_done_timeout"}, 32'd0, 32'd1);
    chk({name, "_points"}, idx, exp_k);
    @(posedge clk);
    #1;
    chk({name, "_busy_idle"}, {31'd0, bus.o_busy}, 32'd0);
    chk({name, "_done_pulse"}, {31'd0, bus.o_done}, 32'd0);
    chk({name, "_count_hold"}, {11'd0, bus.o_count}, exp_k);
    bus.i_out_ready = 1'b1;
  endtask

  initial begin
    int  accepted;
    bit  got_second;
    bit  done_seen;

    rst             = 1'b1;
    bus.i_start     = 1'b0;
    bus.i_out_ready = 1'b1;
    set_vertices(0, 0, 0, 0, 0, 0);
    #1;
    // Reset values.
    chk("rst_busy",  {31'd0, bus.o_busy},      32'd0);
    chk("rst_valid", {31'd0, bus.o_out_valid}, 32'd0);
    chk("rst_x",     {22'd0, bus.o_out_x},     32'd0);
    chk("rst_y",     {22'd0, bus.o_out_y},     32'd0);
    chk("rst_done",  {31'd0, bus.o_done},      32'd0);
    chk("rst_count", {11'd0, bus.o_count},     32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Right triangle: interior (1,1),(2,1),(1,2); N=25, k=3 -> edge 29.
    exp_k = 3;
    exp_x[0] = 1; exp_y[0] = 1;
    exp_x[1] = 2; exp_y[1] = 1;
    exp_x[2] = 1; exp_y[2] = 2;
    run_job("tri", 0, 0, 4, 0, 0, 4, 0, 29);

    // Reversed winding: same points and timing.
    run_job("rev", 0, 0, 0, 4, 4, 0, 0, 29);

    // Collinear: nothing emitted, N=25 -> edge 26.
    exp_k = 0;
    run_job("colin", 0, 0, 2, 2, 4, 4, 0, 26);

    // Consumer stalls three cycles on the first point -> edge 32.
    exp_k = 3;
    run_job("stall", 0, 0, 4, 0, 0, 4, 3, 32);

    // Box at the top of the coordinate range: one point, N=16 -> edge 18.
    exp_k = 1;
    exp_x[0] = 1022; exp_y[0] = 1022;
    run_job("corner", 1023, 1023, 1020, 1023, 1023, 1020, 0, 18);

    // Reset in EMIT: take the first point, hold the second, then reset.
    set_vertices(0, 0, 4, 0, 0, 4);
    bus.i_out_ready = 1'b1;
    bus.i_start     = 1'b1;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    accepted    = 0;
    got_second  = 1'b0;
    for (int c = 0; c < 100 && !got_second; c++) begin
      @(posedge clk);
      #1;
      if (bus.o_out_valid) begin
        if (accepted == 0) begin
          accepted = 1;
        end else begin
          bus.i_out_ready = 1'b0;
          got_second      = 1'b1;
        end
      end
    end
    chk("mid_second_point", {31'd0, got_second}, 32'd1);
    chk("mid_count_before", {11'd0, bus.o_count}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, bus.o_out_valid}, 32'd0);
    chk("mid_rst_busy",  {31'd0, bus.o_busy},      32'd0);
    chk("mid_rst_count", {11'd0, bus.o_count},     32'd0);
    chk("mid_rst_x",     {22'd0, bus.o_out_x},     32'd0);
    @(posedge clk);
    #1;
    rst             = 1'b0;
    bus.i_out_ready = 1'b1;
    done_seen       = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (bus.o_done || bus.o_out_valid || bus.o_busy) done_seen = 1'b1;
    end
    chk("mid_no_activity", {31'd0, done_seen}, 32'd0);

    // Clean rerun after the reset.
    exp_k = 3;
    exp_x[0] = 1; exp_y[0] = 1;
    exp_x[1] = 2; exp_y[1] = 1;
    exp_x[2] = 1; exp_y[2] = 2;
    run_job("rerun", 0, 0, 4, 0, 0, 4, 0, 29);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
